// File: rtl/ex_cond_unit_pkg.sv
// Shared CPU definitions for EX-stage condition handling:
// ARM condition codes, flag bit positions and redirect FSM states.
package ex_cond_unit_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [0:0] redir_state_t;

   localparam redir_state_t ST_IDLE   = 1'b0;
   localparam redir_state_t ST_FLUSH2 = 1'b1;

endpackage

// File: rtl/ex_cond_unit_cond_check.sv
// Combinational ARM condition evaluation against the
// architectural flag register.
module cond_check
   import ex_cond_unit_pkg::*;
(
   input  logic [3:0] condE,
   input  logic [3:0] FlagsQ,
   output logic       CondExE
);

   logic n, z, c, v;

   assign n = FlagsQ[FLAG_N];
   assign z = FlagsQ[FLAG_Z];
   assign c = FlagsQ[FLAG_C];
   assign v = FlagsQ[FLAG_V];

   always_comb begin
      CondExE = 1'b0;
      unique case (condE)
         COND_EQ: CondExE = z;
         COND_NE: CondExE = ~z;
         COND_CS: CondExE = c;
         COND_CC: CondExE = ~c;
         COND_MI: CondExE = n;
         COND_PL: CondExE = ~n;
         COND_VS: CondExE = v;
         COND_VC: CondExE = ~v;
         COND_HI: CondExE = c & ~z;
         COND_LS: CondExE = ~c | z;
         COND_GE: CondExE = (n == v);
         COND_LT: CondExE = (n != v);
         COND_GT: CondExE = ~z & (n == v);
         COND_LE: CondExE = z | (n != v);
         COND_AL: CondExE = 1'b1;
         COND_NV: CondExE = 1'b0;
         default: CondExE = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_cond_unit.sv
// EX-stage condition unit: qualifies controls, owns the flag
// register, the two-cycle redirect flush FSM and a taken counter.
module ex_cond_unit
   import ex_cond_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  condE,
   input  logic [1:0]  FlagWriteE,
   input  logic        PCSrcE,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        BranchE,
   input  logic [3:0]  ALUFlagsE,
   input  logic        StallE,
   output logic        PCSrcG,
   output logic        RegWriteG,
   output logic        MemWriteG,
   output logic        CondExE,
   output logic        FlushD,
   output logic        FlushE,
   output logic [3:0]  FlagsQ,
   output logic [15:0] TakenCnt
);

   redir_state_t state_q;
   redir_state_t state_d;
   logic [3:0]   flags_q;
   logic [15:0]  cnt_q;
   logic         cond_ok;
   logic         in_flush;
   logic         take;

   cond_check u_cond (
      .condE   (condE),
      .FlagsQ  (flags_q),
      .CondExE (cond_ok)
   );

   assign in_flush = (state_q == ST_FLUSH2);

   // the second flush cycle kills whatever sits in EX
   assign PCSrcG    = ~in_flush & (PCSrcE | BranchE) & cond_ok;
   assign RegWriteG = ~in_flush & RegWriteE & cond_ok;
   assign MemWriteG = ~in_flush & MemWriteE & cond_ok;
   assign CondExE   = cond_ok;
   assign FlushD    = in_flush | PCSrcG;
   assign FlushE    = in_flush | PCSrcG;
   assign FlagsQ    = flags_q;
   assign TakenCnt  = cnt_q;

   assign take = ~in_flush & PCSrcG & ~StallE;

   always_comb begin
      state_d = ST_IDLE;
      unique case (state_q)
         ST_IDLE:   state_d = take ? ST_FLUSH2 : ST_IDLE;
         ST_FLUSH2: state_d = StallE ? ST_FLUSH2 : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= 4'b0000;
      end else if (~StallE & cond_ok) begin
         if (FlagWriteE[1]) begin
            flags_q[FLAG_N:FLAG_Z] <= ALUFlagsE[FLAG_N:FLAG_Z];
         end
         if (FlagWriteE[0]) begin
            flags_q[FLAG_C:FLAG_V] <= ALUFlagsE[FLAG_C:FLAG_V];
         end
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else if (take && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_ex_cond_unit.sv
// Self-checking bench for ex_cond_unit: directed cases plus
// randomized traffic against a behavioural reference model.
module tb_ex_cond_unit;

   logic        clk;
   logic        rst;
   logic [3:0]  condE;
   logic [1:0]  FlagWriteE;
   logic        PCSrcE;
   logic        RegWriteE;
   logic        MemWriteE;
   logic        BranchE;
   logic [3:0]  ALUFlagsE;
   logic        StallE;
   logic        PCSrcG;
   logic        RegWriteG;
   logic        MemWriteG;
   logic        CondExE;
   logic        FlushD;
   logic        FlushE;
   logic [3:0]  FlagsQ;
   logic [15:0] TakenCnt;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [3:0]  m_flags;
   logic [15:0] m_cnt;
   bit          m_flush2;

   ex_cond_unit dut (
      .clk        (clk),
      .rst        (rst),
      .condE      (condE),
      .FlagWriteE (FlagWriteE),
      .PCSrcE     (PCSrcE),
      .RegWriteE  (RegWriteE),
      .MemWriteE  (MemWriteE),
      .BranchE    (BranchE),
      .ALUFlagsE  (ALUFlagsE),
      .StallE     (StallE),
      .PCSrcG     (PCSrcG),
      .RegWriteG  (RegWriteG),
      .MemWriteG  (MemWriteG),
      .CondExE    (CondExE),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .FlagsQ     (FlagsQ),
      .TakenCnt   (TakenCnt)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // ARM style: odd codes are the inverse of the even one below
   function automatic bit cond_ok(input logic [3:0] c,
                                  input logic [3:0] f);
      bit n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      base = 1'b0;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = (n == v) && !z;
         default: return (c[0] == 1'b0);
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         m_flags  = 4'b0000;
         m_cnt    = 16'd0;
         m_flush2 = 1'b0;
      end else begin
         bit ok;
         bit pcs;
         ok  = cond_ok(condE, m_flags);
         pcs = !m_flush2 && (PCSrcE || BranchE) && ok;
         if (!StallE && ok) begin
            if (FlagWriteE[1]) m_flags[3:2] = ALUFlagsE[3:2];
            if (FlagWriteE[0]) m_flags[1:0] = ALUFlagsE[1:0];
         end
         if (m_flush2) begin
            if (!StallE) m_flush2 = 1'b0;
         end else if (pcs && !StallE) begin
            m_flush2 = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
      end
   end

   // outputs are checked every cycle, mid-way between edges
   always @(posedge clk) begin
      bit ok, pcs;
      #3;
      ok  = cond_ok(condE, m_flags);
      pcs = !m_flush2 && (PCSrcE || BranchE) && ok;
      check("CondExE", 16'(CondExE), 16'(ok));
      check("PCSrcG", 16'(PCSrcG), 16'(pcs));
      check("RegWriteG", 16'(RegWriteG),
            16'(!m_flush2 && RegWriteE && ok));
      check("MemWriteG", 16'(MemWriteG),
            16'(!m_flush2 && MemWriteE && ok));
      check("FlushD", 16'(FlushD), 16'(m_flush2 || pcs));
      check("FlushE", 16'(FlushE), 16'(m_flush2 || pcs));
      check("FlagsQ", 16'(FlagsQ), 16'(m_flags));
      check("TakenCnt", TakenCnt, m_cnt);
   end

   // applied just after posedge, well before the negedge update
   task automatic drive(input logic [3:0] c, input logic [1:0] fw,
                        input logic pc, input logic rw,
                        input logic mw, input logic br,
                        input logic [3:0] alu, input logic st);
      @(posedge clk);
      #1;
      condE = c; FlagWriteE = fw; PCSrcE = pc; RegWriteE = rw;
      MemWriteE = mw; BranchE = br; ALUFlagsE = alu; StallE = st;
      #1;
   endtask

   task automatic idle_in();
      drive(4'b1111, 2'b00, 0, 0, 0, 0, 4'b0000, 0);
   endtask

   initial begin
      rst = 1'b1;
      condE = 4'b1111; FlagWriteE = 2'b00; PCSrcE = 0; RegWriteE = 0;
      MemWriteE = 0; BranchE = 0; ALUFlagsE = 4'b0000; StallE = 0;
      #2;
      check("rst_flags", 16'(FlagsQ), 16'h0);
      check("rst_cnt", TakenCnt, 16'h0);
      check("rst_flushd", 16'(FlushD), 16'h0);
      @(posedge clk); #1 rst = 1'b0;

      // flag write then EQ uses the new Z
      drive(4'b1110, 2'b11, 0, 0, 0, 0, 4'b0100, 0);
      check("al_cond", 16'(CondExE), 16'h1);
      drive(4'b0000, 2'b00, 0, 1, 0, 0, 4'b0000, 0);
      check("flags_0100", 16'(FlagsQ), 16'h4);
      check("eq_regwr", 16'(RegWriteG), 16'h1);

      // N,Z only: C,V stay clear
      drive(4'b1110, 2'b10, 0, 0, 0, 0, 4'b1011, 0);
      idle_in();
      check("partial_1000", 16'(FlagsQ), 16'h8);

      // failed EQ blocks store and flag write
      drive(4'b1110, 2'b11, 0, 0, 0, 0, 4'b0000, 0);
      drive(4'b0000, 2'b11, 0, 0, 1, 0, 4'b1111, 0);
      check("fail_memwr", 16'(MemWriteG), 16'h0);
      idle_in();
      check("fail_flags", 16'(FlagsQ), 16'h0);

      // taken branch: two flush cycles
      drive(4'b1110, 2'b00, 0, 0, 0, 1, 4'b0000, 0);
      check("br_flushd1", 16'(FlushD), 16'h1);
      check("br_flushe1", 16'(FlushE), 16'h1);
      drive(4'b1110, 2'b00, 0, 1, 0, 0, 4'b0000, 0);
      check("br_flushd2", 16'(FlushD), 16'h1);
      check("br_flushe2", 16'(FlushE), 16'h1);
      check("br_regwr2", 16'(RegWriteG), 16'h0);
      check("br_cnt", TakenCnt, 16'h1);
      drive(4'b1110, 2'b00, 0, 1, 0, 0, 4'b0000, 0);
      check("br_done", 16'(FlushD), 16'h0);
      check("br_regwr3", 16'(RegWriteG), 16'h1);

      // stalled branch never advances
      for (int i = 0; i < 3; i++) begin
         drive(4'b1110, 2'b00, 0, 0, 0, 1, 4'b0000, 1);
         check("stall_flush", 16'(FlushD), 16'h1);
      end
      idle_in();
      check("stall_idle", 16'(FlushD), 16'h0);
      check("stall_cnt", TakenCnt, 16'h1);

      // saturation
      @(posedge clk); #1;
      force dut.cnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1 release dut.cnt_q;
      drive(4'b1110, 2'b00, 1, 0, 0, 0, 4'b0000, 0);
      idle_in();
      check("sat_cnt", TakenCnt, 16'hFFFF);

      // reset mid-FLUSH2
      drive(4'b1110, 2'b11, 0, 0, 0, 1, 4'b1010, 0);
      @(posedge clk); #1;
      condE = 4'b1111; BranchE = 0; FlagWriteE = 2'b00;
      check("pre_rst_flush", 16'(FlushD), 16'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_flushd", 16'(FlushD), 16'h0);
      check("mid_rst_flushe", 16'(FlushE), 16'h0);
      check("mid_rst_flags", 16'(FlagsQ), 16'h0);
      check("mid_rst_cnt", TakenCnt, 16'h0);
      @(posedge clk); #1 rst = 1'b0;

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         condE      = 4'($urandom_range(0, 15));
         FlagWriteE = 2'($urandom_range(0, 3));
         PCSrcE     = ($urandom_range(0, 5) == 0);
         BranchE    = ($urandom_range(0, 5) == 0);
         RegWriteE  = 1'($urandom_range(0, 1));
         MemWriteE  = 1'($urandom_range(0, 1));
         ALUFlagsE  = 4'($urandom_range(0, 15));
         StallE     = ($urandom_range(0, 3) == 0);
         rst        = ($urandom_range(0, 99) == 0);
      end
      @(posedge clk); #1 rst = 1'b0;
      idle_in();
      @(posedge clk); #4;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
